hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline-control counterpart to the forwarding logic: it handles the hazards that forwarding cannot resolve.
- Detects load-use RAW hazards, taken-branch control hazards and data-memory wait states.
- Drives stall, flush and bubble controls to the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Holds a small FSM, a memory-wait timeout counter and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, consecutive unacknowledged dmem wait cycles before mem_timeout is raised (>=1).
- CNT_W, 32, width of the performance counters.
- TO_W, 5, width of the wait counter; must satisfy 2**TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_IF_ID  in  5  source register 1 of the instruction in decode.
- rs2_IF_ID  in  5  source register 2 of the instruction in decode.
- useRs1  in  1  decode instruction reads rs1.
- useRs2  in  1  decode instruction reads rs2.
- memRd_ID_EX  in  1  instruction in EX is a load.
- rdst_ID_EX  in  5  destination register of the instruction in EX.
- brTaken_EX  in  1  branch or jump resolved taken in EX.
- dmemReq  in  1  MEM stage is issuing a load or store this cycle.
- dmemAck  in  1  data memory completes the request this cycle.
- pcStall  out  1  hold the PC.
- ifIdStall  out  1  hold the IF/ID register.
- ifIdFlush  out  1  zero IF/ID (insert NOP).
- idExStall  out  1  hold the ID/EX register.
- idExBubble  out  1  load a NOP into ID/EX.
- exMemStall  out  1  hold the EX/MEM register.
- memWbBubble  out  1  load a NOP into MEM/WB.
- memTimeout  out  1  sticky flag: wait limit exceeded.
- stallCycles  out  CNT_W  saturating count of cycles with pcStall=1.
- flushCount  out  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Reset: while rst=1, all control outputs are 0 in that cycle, the FSM goes to RUN, and waitCnt, memTimeout, stallCycles and flushCount clear. Reset takes priority over every event, including reset in the middle of MEM_WAIT.
- States are RUN and MEM_WAIT. Control outputs are combinational from state and inputs (zero-latency). Counters and state are registered.
- Priority in RUN, and in the MEM_WAIT cycle where dmemAck=1, is: memory wait > branch flush > load-use.
  - Memory wait (dmemReq=1, dmemAck=0):
    - Assert pcStall, ifIdStall, idExStall, exMemStall and memWbBubble.
    - Go to MEM_WAIT and set waitCnt=1.
  - Branch flush (brTaken_EX=1):
    - Assert ifIdFlush and idExBubble; do not assert pcStall, so the PC loads the branch target.
    - flushCount increments. Branch flush overrides a simultaneous load-use hazard.
  - Load-use: memRd_ID_EX=1, rdst_ID_EX!=0, and (useRs1 and rs1_IF_ID==rdst_ID_EX) or (useRs2 and rs2_IF_ID==rdst_ID_EX).
    - Assert pcStall, ifIdStall and idExBubble for that cycle.
    - Exactly one cycle is inserted, because the load advances and forwarding covers the rest.
    - x0 never causes a stall.
- A zero-wait access (dmemReq=1 and dmemAck=1 in the same cycle) causes no stall.
- MEM_WAIT with dmemAck=0:
  - Assert the same freeze set as a memory wait.
  - waitCnt increments, saturating at 2**TO_W-1.
  - When waitCnt reaches MEM_TIMEOUT, memTimeout is set at the next edge and stays set until rst.
  - The FSM keeps waiting; there is no abort.
- MEM_WAIT with dmemAck=1:
  - Release the freeze in that cycle and evaluate branch and load-use with RUN rules.
  - Go to RUN and clear waitCnt.
- A branch or load-use hazard present during a freeze is held by the frozen registers and handled on release.
- dmemReq dropping while in MEM_WAIT is illegal; the bench asserts that it never happens.
- stallCycles increments in every cycle with pcStall=1; it and flushCount saturate at all-ones and never wrap.

Decomposition:
- Shared package holds:
  - the state encoding constants (ST_RUN, ST_MEM_WAIT);
  - the x0 register constant (5'd0);
  - default parameter values.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output count) is instantiated twice, for the two performance counters.

Test Plan:
- Load x5 in EX (memRd_ID_EX=1, rdst_ID_EX=5), decode reads rs2=5 with useRs2=1 -> one cycle of pcStall=ifIdStall=idExBubble=1, stallCycles=1. Same case with rdst_ID_EX=0 or useRs2=0 -> no stall.
- brTaken_EX=1 together with a load-use match -> ifIdFlush=idExBubble=1, pcStall=0, flushCount=1.
- dmemReq=1 with dmemAck low for 3 cycles, high on the 4th -> freeze asserted 3 cycles, released in the ack cycle, state RUN, stallCycles=3. dmemReq and dmemAck high together -> no freeze.
- dmemReq=1 with dmemAck held low for 20 cycles (MEM_TIMEOUT=16) -> memTimeout rises after the 16th wait cycle and stays 1 after a later ack.
- rst pulsed for 1 cycle mid-MEM_WAIT -> all outputs 0 in that cycle, counters and memTimeout 0, FSM in RUN.
- Force both counters to all-ones at CNT_W=4 (16 stalls, 16 flushes) -> both hold at 15.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: FSM states, x0 constant, defaults.
package hazard_unit_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // Architectural zero register; a write to it never creates a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TO_W        = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc until every bit is set, then hold.
  always_ff @(posedge clk) begin
    if (rst)                         count <= '0;
    else if (inc && (count != '1))   count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, taken-branch flushes and dmem wait freezes,
// with a wait-timeout flag and saturating stall/flush performance counters.
// TO_W must be wide enough that 2**TO_W > MEM_TIMEOUT.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_IF_ID,
  input  logic [4:0]       rs2_IF_ID,
  input  logic             useRs1,
  input  logic             useRs2,
  input  logic             memRd_ID_EX,
  input  logic [4:0]       rdst_ID_EX,
  input  logic             brTaken_EX,
  input  logic             dmemReq,
  input  logic             dmemAck,
  output logic             pcStall,
  output logic             ifIdStall,
  output logic             ifIdFlush,
  output logic             idExStall,
  output logic             idExBubble,
  output logic             exMemStall,
  output logic             memWbBubble,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            mem_timeout_q;
  logic            load_use;
  logic            mem_freeze;   // raw freeze condition, ignoring reset
  logic            freeze;       // freeze as driven to the pipeline
  logic            br_flush;
  logic            lu_stall;

  // RAW on a load result the EX stage cannot yet forward; x0 is never a real producer.
  always_comb begin
    load_use = memRd_ID_EX && (rdst_ID_EX != REG_X0) &&
               ((useRs1 && (rs1_IF_ID == rdst_ID_EX)) ||
                (useRs2 && (rs2_IF_ID == rdst_ID_EX)));
  end

  // Next state, wait-count update and prioritised controls: mem wait > branch > load-use.
  always_comb begin
    mem_freeze = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        mem_freeze = dmemReq && !dmemAck;
        state_d    = mem_freeze ? ST_MEM_WAIT : ST_RUN;
        wait_cnt_d = TO_ONE;
      end
      ST_MEM_WAIT: begin
        // Keep waiting until the ack; an unexpected req drop does not release the freeze.
        mem_freeze = !dmemAck;
        state_d    = mem_freeze ? ST_MEM_WAIT : ST_RUN;
        wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + TO_ONE;
      end
      default: begin
        mem_freeze = 1'b0;
        state_d    = ST_RUN;
      end
    endcase
    freeze   = !rst && mem_freeze;
    br_flush = !rst && !mem_freeze && brTaken_EX;
    lu_stall = !rst && !mem_freeze && !brTaken_EX && load_use;
  end

  // Drive the pipeline register controls from the resolved hazard.
  always_comb begin
    pcStall     = freeze || lu_stall;
    ifIdStall   = freeze || lu_stall;
    ifIdFlush   = br_flush;
    idExStall   = freeze;
    idExBubble  = br_flush || lu_stall;
    exMemStall  = freeze;
    memWbBubble = freeze;
    memTimeout  = mem_timeout_q;
  end

  // State, wait counter and sticky timeout; timeout latches on the edge the count hits the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (mem_freeze) begin
        wait_cnt_q <= wait_cnt_d;
        if (wait_cnt_d >= TO_LIMIT) mem_timeout_q <= 1'b1;
      end else begin
        wait_cnt_q <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pcStall),
    .count (stallCycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifIdFlush),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic,
// compared each cycle against a cycle-level behavioural model.
module tb_hazard_unit;

  localparam int MT    = 16;
  localparam int CW    = 4;
  localparam int TW    = 5;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int WMAX  = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1_IF_ID, rs2_IF_ID, rdst_ID_EX;
  logic          useRs1, useRs2, memRd_ID_EX, brTaken_EX, dmemReq, dmemAck;
  logic          pcStall, ifIdStall, ifIdFlush, idExStall, idExBubble, exMemStall, memWbBubble;
  logic          memTimeout;
  logic [CW-1:0] stallCycles, flushCount;

  hazard_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW), .TO_W(TW)) dut (
    .clk(clk), .rst(rst),
    .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID),
    .useRs1(useRs1), .useRs2(useRs2),
    .memRd_ID_EX(memRd_ID_EX), .rdst_ID_EX(rdst_ID_EX),
    .brTaken_EX(brTaken_EX), .dmemReq(dmemReq), .dmemAck(dmemAck),
    .pcStall(pcStall), .ifIdStall(ifIdStall), .ifIdFlush(ifIdFlush),
    .idExStall(idExStall), .idExBubble(idExBubble), .exMemStall(exMemStall),
    .memWbBubble(memWbBubble), .memTimeout(memTimeout),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state
  bit m_waiting;
  int m_waits;     // consecutive unacknowledged wait cycles
  bit m_timeout;
  int m_stalls;
  int m_flushes;

  task automatic cyc(input bit r, input logic [4:0] a1, input logic [4:0] a2,
                     input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                     input bit br, input bit rq, input bit ak, input string tag);
    bit       frz, hz, lu, fl;
    logic [6:0] exp_ctl, got_ctl;
    rst = r; rs1_IF_ID = a1; rs2_IF_ID = a2; useRs1 = u1; useRs2 = u2;
    memRd_ID_EX = mr; rdst_ID_EX = rd; brTaken_EX = br; dmemReq = rq; dmemAck = ak;
    assert (r || !m_waiting || rq) else $error("stimulus dropped dmemReq during a wait (%s)", tag);
    @(negedge clk);
    // Expected controls from the hazard rules
    frz = !r && (m_waiting ? !ak : (rq && !ak));
    hz  = mr && (rd != 5'd0) && ((u1 && a1 == rd) || (u2 && a2 == rd));
    fl  = !r && !frz && br;
    lu  = !r && !frz && !br && hz;
    exp_ctl = {frz | lu, frz | lu, fl, frz, fl | lu, frz, frz};
    got_ctl = {pcStall, ifIdStall, ifIdFlush, idExStall, idExBubble, exMemStall, memWbBubble};
    vectors++;
    assert (got_ctl === exp_ctl) else begin
      miscompares++;
      $error("FAIL %s ctl {pc,ifs,iff,ids,idb,exs,mwb} got=%b exp=%b", tag, got_ctl, exp_ctl);
    end
    vectors++;
    assert (memTimeout === m_timeout) else begin
      miscompares++;
      $error("FAIL %s memTimeout got=%b exp=%b", tag, memTimeout, m_timeout);
    end
    vectors++;
    assert (stallCycles === CW'(m_stalls)) else begin
      miscompares++;
      $error("FAIL %s stallCycles got=%0d exp=%0d", tag, stallCycles, m_stalls);
    end
    vectors++;
    assert (flushCount === CW'(m_flushes)) else begin
      miscompares++;
      $error("FAIL %s flushCount got=%0d exp=%0d", tag, flushCount, m_flushes);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_waiting = 0; m_waits = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (frz) begin
        m_waits   = m_waiting ? ((m_waits < WMAX) ? m_waits + 1 : WMAX) : 1;
        m_waiting = 1;
        if (m_waits >= MT) m_timeout = 1;
      end else begin
        m_waiting = 0;
        m_waits   = 0;
      end
      if ((frz || lu) && m_stalls < CMAX) m_stalls++;
      if (fl && m_flushes < CMAX) m_flushes++;
    end
  endtask

  task automatic idle(input string tag);
    cyc(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    cyc(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, "reset");
  endtask

  initial begin
    rst = 1; rs1_IF_ID = 0; rs2_IF_ID = 0; useRs1 = 0; useRs2 = 0;
    memRd_ID_EX = 0; rdst_ID_EX = 0; brTaken_EX = 0; dmemReq = 0; dmemAck = 0;
    m_waiting = 0; m_waits = 0; m_timeout = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk); #1;
    do_reset();
    idle("post_reset");

    // Load-use on rs2 = x5, then non-hazard variants
    cyc(0, 5'd1, 5'd5, 1, 1, 1, 5'd5, 0, 0, 0, "lu_rs2");
    idle("lu_after");
    cyc(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, "lu_x0");
    cyc(0, 5'd1, 5'd5, 1, 0, 1, 5'd5, 0, 0, 0, "lu_nouse");
    cyc(0, 5'd7, 5'd2, 1, 1, 1, 5'd7, 0, 0, 0, "lu_rs1");
    cyc(0, 5'd7, 5'd2, 1, 1, 0, 5'd7, 0, 0, 0, "lu_noload");

    // Branch overrides load-use
    cyc(0, 5'd1, 5'd5, 1, 1, 1, 5'd5, 1, 0, 0, "br_lu");
    idle("br_after");

    // Three wait cycles, ack on the fourth, then a zero-wait access
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 5'd3, 5'd0, 1, 0, 1, 5'd3, 1, 1, 0, "wait3");
    cyc(0, 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 1, 1, "wait3_ack_lu");
    cyc(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, "zero_wait");
    idle("wait3_idle");

    // Timeout: 20 unacked cycles, then ack; flag stays set
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "timeout_wait");
    cyc(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1, "timeout_ack_br");
    idle("timeout_sticky1");
    idle("timeout_sticky2");

    // Reset in the middle of a wait
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, "rst_mid_wait");
    cyc(1, 5'd4, 5'd4, 1, 1, 1, 5'd4, 1, 1, 0, "rst_mid_pulse");
    cyc(0, 5'd4, 5'd4, 1, 1, 1, 5'd4, 0, 0, 0, "rst_mid_after");
    idle("rst_mid_idle");

    // Counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) cyc(0, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0, "sat_stall");
    for (int i = 0; i < 20; i++) cyc(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, "sat_flush");
    idle("sat_hold");

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit r, rq, ak;
      r  = ($urandom_range(0, 79) == 0);
      rq = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
      ak = m_waiting ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      cyc(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          5'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0), rq, ak, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
